// File: rtl/arm_pipeline_pkg.sv
// Shared definitions for the ARM-style pipeline memory stage.
// Data-memory base address, default depth and wait-state FSM encoding.
package arm_pipeline_pkg;

  localparam logic [31:0] MEM_BASE_ADDR     = 32'd1024;
  localparam int          MEM_DEPTH_DEFAULT = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Word offset from the memory base; caller truncates to the array size.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return (addr - MEM_BASE_ADDR) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_unit_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module data_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage_unit.sv
// Pipeline MEM stage with MEM/WB register and data memory.
// MEM_STAGE_WAIT_STATES_EN enables the wait-state stall FSM.
import arm_pipeline_pkg::*;

module mem_stage_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_Pc,
  input  logic        i_Sig_Write_Back_Enable,
  input  logic        i_Sig_Memory_Read_Enable,
  input  logic        i_Sig_Memory_Write_Enable,
  input  logic [31:0] i_ALU_Result,
  input  logic [31:0] i_Value_Rm,
  input  logic [3:0]  i_Destination,
  output logic [31:0] o_Pc,
  output logic [31:0] o_ALU_Result,
  output logic        o_Sig_Write_Back_Enable,
  output logic        o_Sig_Memory_Read_Enable,
  output logic [31:0] o_Memory_Data,
  output logic [3:0]  o_Destination,
  output logic        o_Freeze
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          mem_op;
  logic          stall;
  logic          commit;
  logic          we;

  assign idx    = AW'(word_index(i_ALU_Result));
  assign mem_op = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;

`ifdef MEM_STAGE_WAIT_STATES_EN
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign stall  = 1'b0;
  assign commit = 1'b1;
`endif

  assign o_Freeze = stall;
  assign we = commit & ~stall & ~reset & i_Sig_Memory_Write_Enable;

  data_memory #(
    .DEPTH (MEM_DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (idx),
    .wdata (i_Value_Rm),
    .rdata (rdata)
  );

  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdata_q, mdata_d;
  logic [3:0]  dst_q, dst_d;
  logic        wb_q, wb_d;
  logic        rd_q, rd_d;

  // A stalled cycle loads a bubble; everything else holds.
  always_comb begin
    pc_d    = pc_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    dst_d   = dst_q;
    wb_d    = 1'b0;
    rd_d    = 1'b0;
    if (!stall) begin
      pc_d  = i_Pc;
      alu_d = i_ALU_Result;
      dst_d = i_Destination;
      wb_d  = i_Sig_Write_Back_Enable;
      rd_d  = i_Sig_Memory_Read_Enable;
      if (commit && i_Sig_Memory_Read_Enable) mdata_d = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= 32'd0;
      alu_q   <= 32'd0;
      mdata_q <= 32'd0;
      dst_q   <= 4'd0;
      wb_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      dst_q   <= dst_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
    end
  end

  assign o_Pc                     = pc_q;
  assign o_ALU_Result             = alu_q;
  assign o_Memory_Data            = mdata_q;
  assign o_Destination            = dst_q;
  assign o_Sig_Write_Back_Enable  = wb_q;
  assign o_Sig_Memory_Read_Enable = rd_q;

endmodule
